// File: rtl/uart_core_if.sv
// Word-level handshake bundle between a byte-stream client and uart_core.
// The client uses the master modport and uart_core uses the slave modport.
interface uart_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART with independent TX and RX frame FSMs, LSB-first, 1 or 2 stop bits.
// Defining UART_PARITY_EN adds an even-parity bit to both directions.
module uart_core #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_core_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- transmitter ----------------
  state_e               tx_state, tx_state_n;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_c, tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  always_comb begin
    tx_state_n = tx_state;
    tx_c       = 1'b1;
    tx_bit_end = (tx_cnt == CNT_LAST);
    case (tx_state)
      S_IDLE:  if (bus.tx_valid) tx_state_n = S_START;
      S_START: begin
        tx_c = 1'b0;
        if (tx_bit_end) tx_state_n = S_DATA;
      end
      S_DATA: begin
        tx_c = tx_shift[0];
`ifdef UART_PARITY_EN
        if (tx_bit_end && tx_bit == DATA_LAST) tx_state_n = S_PARITY;
      end
      S_PARITY: begin
        tx_c = tx_par;
        if (tx_bit_end) tx_state_n = S_STOP;
`else
        if (tx_bit_end && tx_bit == DATA_LAST) tx_state_n = S_STOP;
`endif
      end
      S_STOP:  if (tx_bit_end && tx_bit == STOP_LAST) tx_state_n = S_IDLE;
      default: tx_state_n = S_IDLE;
    endcase
  end

  // tx is the registered line level of the current state, so it moves one edge after the state
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx           <= 1'b1;
      bus.tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      tx_state     <= tx_state_n;
      tx           <= tx_c;
      bus.tx_ready <= (tx_state_n == S_IDLE);
      if (tx_state == S_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (bus.tx_valid) begin
          tx_shift <= bus.tx_data;
`ifdef UART_PARITY_EN
          tx_par   <= ^bus.tx_data;
`endif
        end
      end else begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
        if (tx_bit_end) begin
          tx_bit <= (tx_state_n != tx_state) ? '0 : tx_bit + BIT_W'(1);
          if (tx_state == S_DATA) tx_shift <= tx_shift >> 1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2;
  state_e               rx_state, rx_state_n;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_sample, rx_done;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad;
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_sample  = 1'b0;
    rx_done    = 1'b0;
    case (rx_state)
      S_IDLE:  if (!rx_s2) rx_state_n = S_START;
      S_START: if (rx_cnt == CNT_HALF) begin
        rx_sample  = 1'b1;
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == CNT_LAST) begin
        rx_sample = 1'b1;
`ifdef UART_PARITY_EN
        if (rx_bit == DATA_LAST) rx_state_n = S_PARITY;
      end
      S_PARITY: if (rx_cnt == CNT_LAST) begin
        rx_sample  = 1'b1;
        rx_state_n = S_STOP;
`else
        if (rx_bit == DATA_LAST) rx_state_n = S_STOP;
`endif
      end
      // Leave at the stop-bit centre so a following start edge is not missed
      S_STOP: if (rx_cnt == CNT_LAST) begin
        rx_sample  = 1'b1;
        rx_done    = 1'b1;
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1             <= 1'b1;
      rx_s2             <= 1'b1;
      rx_state          <= S_IDLE;
      rx_cnt            <= '0;
      rx_bit            <= '0;
      rx_shift          <= '0;
      bus.rx_data       <= '0;
      bus.rx_valid      <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
      bus.rx_parity_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad        <= 1'b0;
`endif
    end else begin
      rx_s1        <= rx;
      rx_s2        <= rx_s1;
      rx_state     <= rx_state_n;
      bus.rx_valid <= rx_done;
      rx_cnt       <= (rx_state == S_IDLE || rx_sample) ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state == S_IDLE) begin
        rx_bit <= '0;
      end else if (rx_sample && rx_state == S_DATA) begin
        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
        rx_bit   <= rx_bit + BIT_W'(1);
      end
`ifdef UART_PARITY_EN
      if (rx_sample && rx_state == S_PARITY) rx_par_bad <= (^rx_shift) ^ rx_s2;
`endif
      if (rx_done) begin
        bus.rx_data      <= rx_shift;
        bus.rx_frame_err <= !rx_s2;
`ifdef UART_PARITY_EN
        bus.rx_parity_err <= rx_par_bad;
`else
        bus.rx_parity_err <= 1'b0;
`endif
      end
    end
  end
endmodule
